// File: rtl/stream_regroup.sv
// stream_regroup
// Symbol-width converter between two valid/ready streams. Widens (packs
// several narrow input symbols into one output word) or narrows (splits one
// wide input word into several output pieces) by any integer ratio, or acts
// as a single register stage when the widths are equal. Carries a packet end
// marker; when widening, a packet ending mid-word flushes a partial word.
//
// Ports
//   clk        rising-edge system clock
//   reset      asynchronous, active-low; low clears all state immediately
//   in_valid   in_data/in_last presented
//   in_data    input symbol, IN_WIDTH bits
//   in_last    final symbol of a packet
//   in_ready   input symbol accepted when in_valid && in_ready at clk edge
//   out_valid  out_data/out_last/out_fill presented
//   out_data   output symbol, OUT_WIDTH bits
//   out_last   final output symbol of a packet
//   out_fill   widening: input symbols held in out_data (1..RATIO); else 1
//   out_ready  consumer accepts when out_valid && out_ready
//
// MSB_FIRST = 0: first symbol uses the lowest bits; 1: the highest bits.
module stream_regroup #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 8,
  parameter int MSB_FIRST = 0,
  localparam int RATIO  = (IN_WIDTH > OUT_WIDTH) ? (IN_WIDTH / OUT_WIDTH)
                                                 : (OUT_WIDTH / IN_WIDTH),
  localparam int FILL_W = $clog2(RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [FILL_W-1:0]    out_fill,
  input  logic                 out_ready
);

  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RATIO - 1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  logic accept;
  assign accept = in_valid && in_ready;

  if (OUT_WIDTH > IN_WIDTH) begin : g_widen
    logic [OUT_WIDTH-1:0] acc_q, acc_d, data_q, data_d, word;
    logic [CNT_W-1:0]     cnt_q, cnt_d, slot;
    logic                 valid_q, valid_d, last_q, last_d;
    logic [FILL_W-1:0]    fill_q, fill_d;

    // A completed word can be replaced in the same cycle it is consumed.
    assign in_ready = !valid_q || out_ready;

    always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      fill_d  = fill_q;

      // Slot the incoming symbol into the accumulator image. Unfilled slots
      // are already zero because the accumulator clears after every word.
      slot = (MSB_FIRST != 0) ? (LAST_CNT - cnt_q) : cnt_q;
      word = acc_q;
      for (int s = 0; s < RATIO; s++) begin
        if (slot == CNT_W'(s)) begin
          word[s*IN_WIDTH +: IN_WIDTH] = in_data;
        end
      end

      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end

      if (accept) begin
        if (cnt_q == LAST_CNT || in_last) begin
          data_d  = word;
          valid_d = 1'b1;
          last_d  = in_last;
          fill_d  = FILL_W'(cnt_q) + FILL_ONE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d = word;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        fill_q  <= '0;
      end else begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        data_q  <= data_d;
        valid_q <= valid_d;
        last_q  <= last_d;
        fill_q  <= fill_d;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_fill  = fill_q;

  end else if (IN_WIDTH > OUT_WIDTH) begin : g_narrow
    logic [IN_WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d, wlast_q, wlast_d;
    logic [FILL_W-1:0]   fill_q, fill_d;

    // A new word may load in the same cycle the final piece is consumed, so
    // consecutive words stream out without a bubble.
    assign in_ready = !valid_q || (out_ready && cnt_q == LAST_CNT);

    always_comb begin
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      wlast_d = wlast_q;
      fill_d  = fill_q;

      if (valid_q && out_ready) begin
        if (cnt_q == LAST_CNT) begin
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          sh_d  = (MSB_FIRST != 0) ? (sh_q << OUT_WIDTH) : (sh_q >> OUT_WIDTH);
        end
      end

      if (accept) begin
        sh_d    = in_data;
        cnt_d   = '0;
        valid_d = 1'b1;
        wlast_d = in_last;
        fill_d  = FILL_ONE;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sh_q    <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        wlast_q <= 1'b0;
        fill_q  <= '0;
      end else begin
        sh_q    <= sh_d;
        cnt_q   <= cnt_d;
        valid_q <= valid_d;
        wlast_q <= wlast_d;
        fill_q  <= fill_d;
      end
    end

    // The current piece always sits at the end of the shift register that
    // is emitted first.
    assign out_valid = valid_q;
    assign out_data  = (MSB_FIRST != 0) ? sh_q[IN_WIDTH-1 -: OUT_WIDTH]
                                        : sh_q[OUT_WIDTH-1:0];
    assign out_last  = valid_q && wlast_q && (cnt_q == LAST_CNT);
    assign out_fill  = fill_q;

  end else begin : g_pass
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d, last_q, last_d;
    logic [FILL_W-1:0]    fill_q, fill_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      fill_d  = fill_q;
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
      if (accept) begin
        data_d  = in_data;
        valid_d = 1'b1;
        last_d  = in_last;
        fill_d  = FILL_ONE;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        fill_q  <= '0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        last_q  <= last_d;
        fill_q  <= fill_d;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_fill  = fill_q;
  end

endmodule

// File: tb/tb_stream_regroup.sv
// tb_stream_regroup
// Four converter instances: w (2->8, LSB first), n (8->2, LSB first),
// m (8->16, MSB first) and t (6->2, ratio 3). A negedge monitor turns every
// input accept into expected output records using plain arithmetic on whole
// words, and logs every output handshake. Each test task checks its own
// results inline.
module tb_stream_regroup;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  fill;
    int          cyc;
  } rec_t;

  // Instance w: 2 -> 8, LSB first
  logic w_in_valid, w_in_last, w_in_ready, w_out_valid, w_out_last, w_out_ready;
  logic [1:0] w_in_data;
  logic [7:0] w_out_data;
  logic [2:0] w_out_fill;
  // Instance n: 8 -> 2, LSB first
  logic n_in_valid, n_in_last, n_in_ready, n_out_valid, n_out_last, n_out_ready;
  logic [7:0] n_in_data;
  logic [1:0] n_out_data;
  logic [2:0] n_out_fill;
  // Instance m: 8 -> 16, MSB first
  logic m_in_valid, m_in_last, m_in_ready, m_out_valid, m_out_last, m_out_ready;
  logic [7:0]  m_in_data;
  logic [15:0] m_out_data;
  logic [1:0]  m_out_fill;
  // Instance t: 6 -> 2, LSB first
  logic t_in_valid, t_in_last, t_in_ready, t_out_valid, t_out_last, t_out_ready;
  logic [5:0] t_in_data;
  logic [1:0] t_out_data;
  logic [1:0] t_out_fill;

  stream_regroup #(.IN_WIDTH(2), .OUT_WIDTH(8), .MSB_FIRST(0)) u_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_data(w_in_data),
    .in_last(w_in_last), .in_ready(w_in_ready), .out_valid(w_out_valid),
    .out_data(w_out_data), .out_last(w_out_last), .out_fill(w_out_fill),
    .out_ready(w_out_ready));

  stream_regroup #(.IN_WIDTH(8), .OUT_WIDTH(2), .MSB_FIRST(0)) u_n (
    .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_data(n_in_data),
    .in_last(n_in_last), .in_ready(n_in_ready), .out_valid(n_out_valid),
    .out_data(n_out_data), .out_last(n_out_last), .out_fill(n_out_fill),
    .out_ready(n_out_ready));

  stream_regroup #(.IN_WIDTH(8), .OUT_WIDTH(16), .MSB_FIRST(1)) u_m (
    .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_data(m_in_data),
    .in_last(m_in_last), .in_ready(m_in_ready), .out_valid(m_out_valid),
    .out_data(m_out_data), .out_last(m_out_last), .out_fill(m_out_fill),
    .out_ready(m_out_ready));

  stream_regroup #(.IN_WIDTH(6), .OUT_WIDTH(2), .MSB_FIRST(0)) u_t (
    .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_data(t_in_data),
    .in_last(t_in_last), .in_ready(t_in_ready), .out_valid(t_out_valid),
    .out_data(t_out_data), .out_last(t_out_last), .out_fill(t_out_fill),
    .out_ready(t_out_ready));

  // Reference model: expected and observed output records per instance.
  rec_t w_exp[$], n_exp[$], m_exp[$], t_exp[$];
  rec_t w_obs[$], n_obs[$], m_obs[$], t_obs[$];
  logic [31:0] w_pend[$], m_pend[$];

  // Value of a word built from symbols; symbol i weighs 2^(in_w*slot).
  function automatic logic [31:0] pack(input logic [31:0] syms[$], input int in_w,
                                       input int ratio, input bit msb);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < syms.size(); i++) begin
      int slot;
      slot = msb ? (ratio - 1 - i) : i;
      acc = acc + syms[i] * (32'd1 << (slot * in_w));
    end
    return acc;
  endfunction

  // k-th emitted piece of a wide word.
  function automatic logic [31:0] piece(input logic [31:0] word, input int out_w,
                                        input int ratio, input bit msb, input int k);
    int idx;
    idx = msb ? (ratio - 1 - k) : k;
    return (word >> (idx * out_w)) & ((32'd1 << out_w) - 32'd1);
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (!reset) begin
      w_pend.delete();
      m_pend.delete();
    end else begin
      r.cyc = 0;
      if (w_in_valid && w_in_ready) begin
        w_pend.push_back(32'(w_in_data));
        if (w_pend.size() == 4 || w_in_last) begin
          r.data = pack(w_pend, 2, 4, 1'b0);
          r.last = w_in_last;
          r.fill = 4'(w_pend.size());
          w_exp.push_back(r);
          w_pend.delete();
        end
      end
      if (m_in_valid && m_in_ready) begin
        m_pend.push_back(32'(m_in_data));
        if (m_pend.size() == 2 || m_in_last) begin
          r.data = pack(m_pend, 8, 2, 1'b1);
          r.last = m_in_last;
          r.fill = 4'(m_pend.size());
          m_exp.push_back(r);
          m_pend.delete();
        end
      end
      if (n_in_valid && n_in_ready) begin
        for (int k = 0; k < 4; k++) begin
          r.data = piece(32'(n_in_data), 2, 4, 1'b0, k);
          r.last = n_in_last && (k == 3);
          r.fill = 4'd1;
          n_exp.push_back(r);
        end
      end
      if (t_in_valid && t_in_ready) begin
        for (int k = 0; k < 3; k++) begin
          r.data = piece(32'(t_in_data), 2, 3, 1'b0, k);
          r.last = t_in_last && (k == 2);
          r.fill = 4'd1;
          t_exp.push_back(r);
        end
      end
      r.cyc = cyc;
      if (w_out_valid && w_out_ready) begin
        r.data = 32'(w_out_data); r.last = w_out_last; r.fill = 4'(w_out_fill);
        w_obs.push_back(r);
      end
      if (n_out_valid && n_out_ready) begin
        r.data = 32'(n_out_data); r.last = n_out_last; r.fill = 4'(n_out_fill);
        n_obs.push_back(r);
      end
      if (m_out_valid && m_out_ready) begin
        r.data = 32'(m_out_data); r.last = m_out_last; r.fill = 4'(m_out_fill);
        m_obs.push_back(r);
      end
      if (t_out_valid && t_out_ready) begin
        r.data = 32'(t_out_data); r.last = t_out_last; r.fill = 4'(t_out_fill);
        t_obs.push_back(r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    w_in_valid = 0; w_in_last = 0; w_in_data = '0; w_out_ready = 1;
    n_in_valid = 0; n_in_last = 0; n_in_data = '0; n_out_ready = 1;
    m_in_valid = 0; m_in_last = 0; m_in_data = '0; m_out_ready = 1;
    t_in_valid = 0; t_in_last = 0; t_in_data = '0; t_out_ready = 1;
  endtask

  task automatic clear_q();
    w_exp.delete(); n_exp.delete(); m_exp.delete(); t_exp.delete();
    w_obs.delete(); n_obs.delete(); m_obs.delete(); t_obs.delete();
  endtask

  // One dibit into w; assumes w_out_ready is high so it is taken at once.
  task automatic w_send(input logic [1:0] d, input logic last);
    w_in_valid = 1; w_in_data = d; w_in_last = last;
    step();
    w_in_valid = 0; w_in_last = 0;
  endtask

  // One word into t, waiting (bounded) for in_ready.
  task automatic t_send(input logic [5:0] d, input logic last);
    bit ok;
    ok = 0;
    t_in_valid = 1; t_in_data = d; t_in_last = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (t_in_ready) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL t_send_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    t_in_valid = 0; t_in_last = 0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    checks++;
    if ({w_out_valid, w_out_data, w_out_last, w_out_fill} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_w: got %h expected 0", {w_out_valid, w_out_data, w_out_last, w_out_fill});
    end
    checks++;
    if ({n_out_valid, n_out_data, n_out_last, n_out_fill} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_n: got %h expected 0", {n_out_valid, n_out_data, n_out_last, n_out_fill});
    end
    checks++;
    if ({m_out_valid, m_out_data, m_out_last, m_out_fill} !== 20'd0) begin
      errors++;
      $display("[TB] FAIL reset_m: got %h expected 0", {m_out_valid, m_out_data, m_out_last, m_out_fill});
    end
    checks++;
    if ({t_out_valid, t_out_data, t_out_last, t_out_fill} !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_t: got %h expected 0", {t_out_valid, t_out_data, t_out_last, t_out_fill});
    end
    // First accept on the first edge after release; in_last on the first
    // symbol flushes a one-symbol word.
    reset = 1;
    w_send(2'b11, 1'b1);
    checks++;
    if ({w_out_valid, w_out_data, w_out_fill, w_out_last} !== {1'b1, 8'h03, 3'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL first_accept: got v=%b d=%h f=%0d l=%b expected v=1 d=03 f=1 l=1",
               w_out_valid, w_out_data, w_out_fill, w_out_last);
    end
    step();
  endtask

  task automatic test_widen_basic();
    $display("[TB] test_widen_basic");
    w_send(2'b01, 0); w_send(2'b10, 0); w_send(2'b11, 0); w_send(2'b00, 0);
    checks++;
    if ({w_out_valid, w_out_data, w_out_fill, w_out_last} !== {1'b1, 8'h39, 3'd4, 1'b0}) begin
      errors++;
      $display("[TB] FAIL widen_word: got v=%b d=%h f=%0d l=%b expected v=1 d=39 f=4 l=0",
               w_out_valid, w_out_data, w_out_fill, w_out_last);
    end
    step();
    checks++;
    if (w_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL widen_one_cycle: out_valid got %b expected 0", w_out_valid);
    end
  endtask

  task automatic test_narrow_basic();
    logic [1:0] exp_a [4];
    logic [1:0] exp_b [4];
    exp_a = '{2'd0, 2'd1, 2'd3, 2'd2};
    exp_b = '{2'd2, 2'd3, 2'd1, 2'd0};
    $display("[TB] test_narrow_basic");
    n_in_valid = 1; n_in_data = 8'hB4; n_in_last = 1;
    step();
    n_in_valid = 0; n_in_last = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({n_out_valid, n_out_data, n_out_last, n_in_ready} !== {1'b1, exp_a[k], k == 3, k == 3}) begin
        errors++;
        $display("[TB] FAIL narrow_piece%0d: got v=%b d=%0d l=%b rdy=%b expected v=1 d=%0d l=%b rdy=%b",
                 k, n_out_valid, n_out_data, n_out_last, n_in_ready, exp_a[k], k == 3, k == 3);
      end
      step();
    end
    checks++;
    if (n_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL narrow_end: out_valid got %b expected 0", n_out_valid);
    end
    // Stalled first piece must hold.
    n_out_ready = 0;
    n_in_valid = 1; n_in_data = 8'h1E; n_in_last = 0;
    step();
    n_in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({n_out_valid, n_out_data, n_in_ready} !== {1'b1, 2'd2, 1'b0}) begin
        errors++;
        $display("[TB] FAIL narrow_hold: got v=%b d=%0d rdy=%b expected v=1 d=2 rdy=0",
                 n_out_valid, n_out_data, n_in_ready);
      end
      step();
    end
    n_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({n_out_data, n_out_last} !== {exp_b[k], 1'b0}) begin
        errors++;
        $display("[TB] FAIL narrow_after_stall%0d: got d=%0d l=%b expected d=%0d l=0",
                 k, n_out_data, n_out_last, exp_b[k]);
      end
      step();
    end
  endtask

  task automatic test_partial_flush();
    $display("[TB] test_partial_flush");
    w_send(2'b11, 0); w_send(2'b11, 0); w_send(2'b11, 1);
    checks++;
    if ({w_out_valid, w_out_data, w_out_fill, w_out_last} !== {1'b1, 8'h3F, 3'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL flush3: got v=%b d=%h f=%0d l=%b expected v=1 d=3f f=3 l=1",
               w_out_valid, w_out_data, w_out_fill, w_out_last);
    end
    w_send(2'b10, 1);
    checks++;
    if ({w_out_valid, w_out_data, w_out_fill, w_out_last} !== {1'b1, 8'h02, 3'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL flush1: got v=%b d=%h f=%0d l=%b expected v=1 d=02 f=1 l=1",
               w_out_valid, w_out_data, w_out_fill, w_out_last);
    end
    w_send(2'b01, 0); w_send(2'b00, 0); w_send(2'b00, 0); w_send(2'b00, 0);
    checks++;
    if ({w_out_valid, w_out_data, w_out_fill, w_out_last} !== {1'b1, 8'h01, 3'd4, 1'b0}) begin
      errors++;
      $display("[TB] FAIL next_packet: got v=%b d=%h f=%0d l=%b expected v=1 d=01 f=4 l=0",
               w_out_valid, w_out_data, w_out_fill, w_out_last);
    end
    step();
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    m_out_ready = 0;
    m_in_valid = 1; m_in_data = 8'hAA; step();
    m_in_data = 8'h55; step();
    m_in_data = 8'h0F;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({m_out_valid, m_out_data, m_out_fill, m_out_last, m_in_ready} !== {1'b1, 16'hAA55, 2'd2, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got v=%b d=%h f=%0d l=%b rdy=%b expected v=1 d=aa55 f=2 l=0 rdy=0",
                 c, m_out_valid, m_out_data, m_out_fill, m_out_last, m_in_ready);
      end
      step();
    end
    m_out_ready = 1;
    #1;
    checks++;
    if (m_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_rise: in_ready got %b expected 1", m_in_ready);
    end
    step();
    checks++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: out_valid got %b expected 0", m_out_valid);
    end
    m_in_data = 8'hF0; m_in_last = 1;
    step();
    m_in_valid = 0; m_in_last = 0;
    checks++;
    if ({m_out_valid, m_out_data, m_out_fill, m_out_last} !== {1'b1, 16'h0FF0, 2'd2, 1'b1}) begin
      errors++;
      $display("[TB] FAIL bp_third: got v=%b d=%h f=%0d l=%b expected v=1 d=0ff0 f=2 l=1",
               m_out_valid, m_out_data, m_out_fill, m_out_last);
    end
    step();
  endtask

  task automatic test_nonpow2();
    logic [5:0] words [3];
    $display("[TB] test_nonpow2");
    clear_q();
    for (int i = 0; i < 3; i++) words[i] = 6'($urandom);
    t_send(words[0], 0); t_send(words[1], 0); t_send(words[2], 1);
    repeat (6) step();
    checks++;
    if (t_obs.size() != 9) begin
      errors++;
      $display("[TB] FAIL nonpow2_count: got %0d expected 9", t_obs.size());
    end
    for (int i = 0; i < 9 && i < t_obs.size(); i++) begin
      logic [1:0] p;
      p = 2'((words[i / 3] >> (2 * (i % 3))) & 6'h3);
      checks++;
      if ({t_obs[i].data[1:0], t_obs[i].last, t_obs[i].cyc} !== {p, i == 8, t_obs[0].cyc + i}) begin
        errors++;
        $display("[TB] FAIL nonpow2_piece%0d: got d=%0d l=%b cyc=%0d expected d=%0d l=%b cyc=%0d",
                 i, t_obs[i].data, t_obs[i].last, t_obs[i].cyc, p, i == 8, t_obs[0].cyc + i);
      end
    end
  endtask

  task automatic test_midreset();
    $display("[TB] test_midreset");
    w_send(2'b11, 0); w_send(2'b11, 0); w_send(2'b11, 0); w_send(2'b11, 0);
    w_send(2'b01, 0); w_send(2'b10, 0);
    reset = 0;
    #1;
    checks++;
    if ({w_out_valid, w_out_data, w_out_last, w_out_fill} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: got %h expected 0", {w_out_valid, w_out_data, w_out_last, w_out_fill});
    end
    step(); step();
    reset = 1;
    clear_q();
    w_send(2'b10, 0); w_send(2'b01, 0); w_send(2'b11, 0); w_send(2'b01, 0);
    checks++;
    if ({w_out_valid, w_out_data, w_out_fill, w_out_last} !== {1'b1, 8'h76, 3'd4, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_new: got v=%b d=%h f=%0d l=%b expected v=1 d=76 f=4 l=0",
               w_out_valid, w_out_data, w_out_fill, w_out_last);
    end
    step();
    checks++;
    if (w_obs.size() != 1) begin
      errors++;
      $display("[TB] FAIL midreset_words: got %0d expected 1", w_obs.size());
    end
  endtask

  task automatic test_random();
    rec_t e[$], o[$];
    string nm;
    $display("[TB] test_random");
    clear_q();
    for (int c = 0; c < 800; c++) begin
      w_in_valid = ($urandom % 4) != 0; w_in_data = 2'($urandom); w_in_last = ($urandom % 7) == 0;
      n_in_valid = ($urandom % 4) != 0; n_in_data = 8'($urandom); n_in_last = ($urandom % 3) == 0;
      m_in_valid = ($urandom % 4) != 0; m_in_data = 8'($urandom); m_in_last = ($urandom % 5) == 0;
      t_in_valid = ($urandom % 4) != 0; t_in_data = 6'($urandom); t_in_last = ($urandom % 3) == 0;
      w_out_ready = ($urandom % 3) != 0; n_out_ready = ($urandom % 3) != 0;
      m_out_ready = ($urandom % 3) != 0; t_out_ready = ($urandom % 3) != 0;
      step();
    end
    idle_all();
    repeat (20) step();
    for (int id = 0; id < 4; id++) begin
      case (id)
        0: begin e = w_exp; o = w_obs; nm = "rand_w"; end
        1: begin e = n_exp; o = n_obs; nm = "rand_n"; end
        2: begin e = m_exp; o = m_obs; nm = "rand_m"; end
        default: begin e = t_exp; o = t_obs; nm = "rand_t"; end
      endcase
      checks++;
      if (o.size() != e.size() || e.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s count: got %0d expected %0d (nonzero)", nm, o.size(), e.size());
      end
      for (int i = 0; i < o.size() && i < e.size(); i++) begin
        checks++;
        if ({o[i].data, o[i].last, o[i].fill} !== {e[i].data, e[i].last, e[i].fill}) begin
          errors++;
          $display("[TB] FAIL %s item %0d: got d=%h l=%b f=%0d expected d=%h l=%b f=%0d",
                   nm, i, o[i].data, o[i].last, o[i].fill, e[i].data, e[i].last, e[i].fill);
        end
      end
    end
  endtask

  initial begin
    reset = 0;
    idle_all();
    repeat (2) step();
    test_reset();
    test_widen_basic();
    test_narrow_basic();
    test_partial_flush();
    test_backpressure();
    test_nonpow2();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/stream_regroup.md
Name: stream_regroup

Overview:
- Parametrised symbol-width converter between two valid/ready streams; generalises the fixed dibit/byte converters to any integer width ratio in either direction.
- Adds backpressure, an end-of-packet marker with partial-word flush, and selectable symbol order.
- Sits between the RMII dibit side, packet buffers and the crypto/colour paths wherever a stream changes width.

Parameters:
- IN_WIDTH, 2, input symbol width in bits.
- OUT_WIDTH, 8, output symbol width in bits. One of IN_WIDTH/OUT_WIDTH must be an integer multiple of the other; equal widths are allowed.
- MSB_FIRST, 0, 0: first input symbol occupies the lowest bits of a word and narrowing emits the lowest bits first. 1: the highest bits are used first in both directions.
- Derived: RATIO = max(IN_WIDTH, OUT_WIDTH) / min(IN_WIDTH, OUT_WIDTH); FILL_W = clog2(RATIO+1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset. Low immediately clears all state.
- in_valid  input  1  in_data/in_last presented.
- in_data  input  IN_WIDTH  input symbol.
- in_last  input  1  final symbol of packet.
- in_ready  output  1  symbol accepted when in_valid && in_ready at clk edge.
- out_valid  output  1  out_data/out_last/out_fill presented.
- out_data  output  OUT_WIDTH  output symbol.
- out_last  output  1  final output symbol of packet.
- out_fill  output  FILL_W  widening: count of valid input symbols in out_data (1..RATIO); otherwise constant 1.
- out_ready  input  1  consumer accepts when out_valid && out_ready.

Behaviour:
- Reset (reset low, async): out_valid=0, out_data=0, out_last=0, out_fill=0, symbol counter=0, accumulator/shift register=0. A partial word or packet in flight is discarded with no out_last. First accept possible on the first edge after reset is released.
- Output hold rule: out_data, out_last and out_fill stay stable while out_valid && !out_ready.
- Widening (OUT>IN):
  - in_ready = !out_valid || out_ready (combinational).
  - Each accepted symbol goes into slot cnt of the accumulator; the slot order is set by MSB_FIRST.
  - When cnt==RATIO-1, or in_last is set, the next cycle has out_valid=1, out_data=accumulated word with unfilled slots zero, out_fill=cnt+1, out_last=in_last.
  - cnt then returns to 0 and the accumulator clears.
  - Latency: 1 cycle from the completing accept to out_valid. Sustained throughput is 1 input symbol per cycle.
- Narrowing (IN>OUT):
  - in_ready = !out_valid || (out_ready && cnt==RATIO-1).
  - An accept loads the shift register and sets cnt=0 and out_valid=1 on the next cycle.
  - out_data = current piece; each out_ready handshake advances one piece and increments cnt.
  - out_last=1 only on piece RATIO-1 of a word accepted with in_last.
  - An accept is allowed in the same cycle as the final-piece handshake, so there is no bubble; the pieces of consecutive words are back to back.
  - Latency: 1 cycle.
- Equal widths: single register stage. in_ready = !out_valid || out_ready; out_last = registered in_last; out_fill=1.
- Simultaneous events:
  - A handshake on the output and an accept on the input in the same cycle are both honoured.
  - If reset asserts during a handshake cycle, reset wins.
- in_last on the first symbol of a word while widening emits a word with out_fill=1.
- Back-to-back packets need no idle cycle between them.
- Counter wrap: cnt counts 0..RATIO-1 explicitly; it does not depend on RATIO being a power of two.
- in_valid low leaves all state unchanged. in_data is don't-care when in_valid=0.

Test Plan:
- IN=2, OUT=8, MSB_FIRST=0, out_ready=1. Send dibits 2'b01, 2'b10, 2'b11, 2'b00 on consecutive cycles -> one cycle after the 4th accept: out_data=8'h39, out_fill=3'd4, out_last=0, out_valid for exactly one cycle.
- IN=8, OUT=2, MSB_FIRST=0. Send byte 8'hB4 with in_last=1, out_ready=1 -> out_data sequence 0,1,3,2 on 4 consecutive cycles; out_last=1 only on the 4th; in_ready low for cycles 1-3.
- IN=2, OUT=8. Send 3 dibits 2'b11 then in_last on the 3rd -> out_data=8'h3F, out_fill=3, out_last=1; the next packet's first symbol lands in slot 0.
- Backpressure, IN=8, OUT=16, MSB_FIRST=1. Send bytes 8'hAA, 8'h55 with out_ready=0 for 5 cycles -> out_data=16'hAA55 held stable, in_ready=0; the third byte is accepted in the same cycle out_ready rises.
- IN=6, OUT=2 (RATIO=3, non-power-of-2). Stream 3 words back to back -> 9 contiguous out_valid cycles, no bubbles, correct piece order.
- Mid-packet reset: drop reset low after 2 of 4 dibits (IN=2, OUT=8) -> outputs 0 immediately; after release, 4 new dibits produce exactly one word containing only the new data.
